// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: sequences memory, IR, PC, ALU and register writes per instruction.
// Optional build macro ILLEGAL_OP_TRAP_EN adds a TRAP state and the Illegal_Op output.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             Mem_Ready,
   output logic             PC_Write,
   output logic             PC_Write_Cond,
   output logic             PC_Write_Cond_NE,
   output logic             IorD,
   output logic             Mem_Read,
   output logic             Mem_Write,
   output logic             IR_Write,
   output logic [1:0]       Reg_Dst,
   output logic [1:0]       Mem_to_Reg,
   output logic             Reg_Write,
   output logic             ALU_Src_A,
   output logic [1:0]       ALU_Src_B,
   output logic [2:0]       ALU_Op,
   output logic [1:0]       PC_Source,
   output logic [3:0]       State,
   output logic             Instr_Retired,
   output logic [CNT_W-1:0] Instr_Count
`ifdef ILLEGAL_OP_TRAP_EN
   ,
   output logic             Illegal_Op
`endif
);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_XORI  = 6'd14;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;
   localparam logic [2:0] ALU_XOR   = 3'b110;
   localparam logic [2:0] ALU_LUI   = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_I_EXEC    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
      ,
      S_TRAP      = 4'd12
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Whole decode sits under reset so every output drops combinationally while reset is low.
   always_comb begin
      state_d          = state_q;
      PC_Write         = 1'b0;
      PC_Write_Cond    = 1'b0;
      PC_Write_Cond_NE = 1'b0;
      IorD             = 1'b0;
      Mem_Read         = 1'b0;
      Mem_Write        = 1'b0;
      IR_Write         = 1'b0;
      Reg_Dst          = 2'b00;
      Mem_to_Reg       = 2'b00;
      Reg_Write        = 1'b0;
      ALU_Src_A        = 1'b0;
      ALU_Src_B        = 2'b00;
      ALU_Op           = ALU_ADD;
      PC_Source        = 2'b00;
      Instr_Retired    = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               Mem_Read  = 1'b1;
               ALU_Src_B = 2'b01;
               IR_Write  = Mem_Ready;
               PC_Write  = Mem_Ready;
               if (Mem_Ready) state_d = S_DECODE;
            end
            S_DECODE: begin
               ALU_Src_B = 2'b11;
               case (Opcode)
                  OP_RTYPE:                  state_d = S_R_EXEC;
                  OP_LW, OP_SW:              state_d = S_MEM_ADDR;
                  OP_ADDI, OP_SLTI, OP_ANDI,
                  OP_ORI, OP_XORI, OP_LUI:   state_d = S_I_EXEC;
                  OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                  OP_J, OP_JAL:              state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                  default:                   state_d = S_TRAP;
`else
                  default:                   state_d = S_FETCH;
`endif
               endcase
            end
            S_MEM_ADDR: begin
               ALU_Src_A = 1'b1;
               ALU_Src_B = 2'b10;
               state_d   = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
               IorD     = 1'b1;
               Mem_Read = 1'b1;
               if (Mem_Ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
               Mem_to_Reg    = 2'b01;
               Reg_Write     = 1'b1;
               Instr_Retired = 1'b1;
               state_d       = S_FETCH;
            end
            S_MEM_WRITE: begin
               IorD          = 1'b1;
               Mem_Write     = 1'b1;
               Instr_Retired = Mem_Ready;
               if (Mem_Ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
               ALU_Src_A = 1'b1;
               ALU_Op    = ALU_FUNCT;
               state_d   = S_R_WB;
            end
            S_R_WB: begin
               Reg_Dst       = 2'b01;
               Reg_Write     = 1'b1;
               Instr_Retired = 1'b1;
               state_d       = S_FETCH;
            end
            S_I_EXEC: begin
               ALU_Src_A = 1'b1;
               ALU_Src_B = 2'b10;
               case (Opcode)
                  OP_ANDI: ALU_Op = ALU_AND;
                  OP_ORI:  ALU_Op = ALU_OR;
                  OP_SLTI: ALU_Op = ALU_SLT;
                  OP_XORI: ALU_Op = ALU_XOR;
                  OP_LUI:  ALU_Op = ALU_LUI;
                  default: ALU_Op = ALU_ADD;
               endcase
               state_d = S_I_WB;
            end
            S_I_WB: begin
               Reg_Write     = 1'b1;
               Instr_Retired = 1'b1;
               state_d       = S_FETCH;
            end
            S_BRANCH: begin
               ALU_Src_A        = 1'b1;
               ALU_Op           = ALU_SUB;
               PC_Source        = 2'b01;
               PC_Write_Cond    = (Opcode == OP_BEQ);
               PC_Write_Cond_NE = (Opcode == OP_BNE);
               Instr_Retired    = 1'b1;
               state_d          = S_FETCH;
            end
            S_JUMP: begin
               PC_Source     = 2'b10;
               PC_Write      = 1'b1;
               Instr_Retired = 1'b1;
               // jal links PC+4, which FETCH already loaded into the PC.
               if (Opcode == OP_JAL) begin
                  Reg_Dst    = 2'b10;
                  Mem_to_Reg = 2'b10;
                  Reg_Write  = 1'b1;
               end
               state_d = S_FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (Instr_Retired) count_d = count_q + CNT_W'(1);
   end

   assign State       = state_q;
   assign Instr_Count = count_q;
`ifdef ILLEGAL_OP_TRAP_EN
   assign Illegal_Op  = reset && (state_q == S_TRAP);
`endif

endmodule
